// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the fetch stage.
//  - Bubble ("nop") bundle values presented while no instruction is committed.
//  - RV32 opcode constants used by the optional static predecoder.
//  - Fetch FSM state type.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] NOP_PC           = 32'h0000_0000;
  localparam logic [31:0] NOP_PRE_PC       = 32'h0000_0000;
  localparam logic        NOP_COMMIT       = 1'b0;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  localparam logic [6:0]  OPC_JAL          = 7'b110_1111;
  localparam logic [6:0]  OPC_BRANCH       = 7'b110_0011;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // issuing a request for pc_q
    S_WAIT = 2'd1,  // request accepted, waiting for its response
    S_HOLD = 2'd2,  // response received, F->D register stalled
    S_DROP = 2'd3   // waiting for a response made stale by a redirect
  } fetch_state_t;

endpackage

// File: rtl/fetch_predecode.sv
// Next-PC predictor for the fetch stage.
//  Ports: instr (in, 32) instruction being handed off
//         pc    (in, 32) address of instr
//         pre_pc(out,32) predicted address of the following fetch
//  Macro FETCH_BPRED_EN: when defined, JAL targets and backward conditional
//  branches are predicted taken; otherwise the prediction is always pc+4.
module fetch_predecode
  import fetch_unit_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [31:0] pre_pc
);

`ifdef FETCH_BPRED_EN
  logic [31:0] imm_j;
  logic [31:0] imm_b;

  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  // Static prediction: jumps always taken, branches taken only when backward (loop heads).
  always_comb begin
    pre_pc = pc + 32'd4;
    if (instr[6:0] == OPC_JAL) begin
      pre_pc = pc + imm_j;
    end else if ((instr[6:0] == OPC_BRANCH) && instr[31]) begin
      pre_pc = pc + imm_b;
    end else begin
      pre_pc = pc + 32'd4;
    end
  end
`else
  logic unused_instr;

  // Instruction content is irrelevant without the predictor.
  assign unused_instr = ^instr;
  assign pre_pc       = pc + 32'd4;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register plus instruction-memory handshake.
//  Keeps at most one imem request outstanding, presents the fetched
//  instruction as an instr/pc/pre_pc/commit bundle to the F->D register,
//  holds it while that register stalls, and discards responses that were
//  made stale by a redirect from execute.
//  Ports:
//   clk, rst                   clock, synchronous active-high reset
//   ctrl_i_fetch_stall         F->D register stall
//   ctrl_i_redirect(_pc)       redirect request and target from execute
//   imem_o_req/addr            request channel (accepted on req & ready)
//   imem_i_ready               request accept
//   imem_i_rvalid/rdata        response channel, one response per request
//   fetch_o_instr/pc/pre_pc    bundle payload (nop values when not committing)
//   fetch_o_commit             bundle valid; handed off when commit & ~stall
//  Macro FETCH_BPRED_EN (optional): enables static branch prediction in
//  fetch_predecode; undefined build predicts pc+4.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_i_fetch_stall,
  input  logic        ctrl_i_redirect,
  input  logic [31:0] ctrl_i_redirect_pc,
  output logic        imem_o_req,
  output logic [31:0] imem_o_addr,
  input  logic        imem_i_ready,
  input  logic        imem_i_rvalid,
  input  logic [31:0] imem_i_rdata,
  output logic [31:0] fetch_o_instr,
  output logic [31:0] fetch_o_pc,
  output logic [31:0] fetch_o_pre_pc,
  output logic        fetch_o_commit
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  inst_q;
  logic [31:0]  cur_instr;
  logic [31:0]  pred_pc;

  // Instruction under consideration: live response while waiting, latched copy while holding.
  assign cur_instr = (state == S_HOLD) ? inst_q : imem_i_rdata;

  fetch_predecode u_predecode (
    .instr  (cur_instr),
    .pc     (pc_q),
    .pre_pc (pred_pc)
  );

  // Request and bundle outputs; a redirect squashes both in the cycle it arrives.
  always_comb begin
    imem_o_req     = 1'b0;
    imem_o_addr    = {pc_q[31:2], 2'b00};
    fetch_o_commit = NOP_COMMIT;
    case (state)
      S_REQ:   imem_o_req     = ~ctrl_i_redirect;
      S_WAIT:  fetch_o_commit = imem_i_rvalid & ~ctrl_i_redirect;
      S_HOLD:  fetch_o_commit = ~ctrl_i_redirect;
      S_DROP:  fetch_o_commit = NOP_COMMIT;
      default: fetch_o_commit = NOP_COMMIT;
    endcase
    if (fetch_o_commit) begin
      fetch_o_instr  = cur_instr;
      fetch_o_pc     = pc_q;
      fetch_o_pre_pc = pred_pc;
    end else begin
      fetch_o_instr  = NOP_INSTR;
      fetch_o_pc     = NOP_PC;
      fetch_o_pre_pc = NOP_PRE_PC;
    end
  end

  // Fetch FSM, PC register and held-instruction register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      pc_q   <= RESET_PC;
      inst_q <= NOP_INSTR;
    end else if (ctrl_i_redirect) begin
      pc_q <= ctrl_i_redirect_pc & ~32'd3;
      case (state)
        // A request still in flight must have its response swallowed.
        S_WAIT:  state <= imem_i_rvalid ? S_REQ : S_DROP;
        // A stale response arriving together with a new redirect is consumed
        // here; waiting for another would never end.
        S_DROP:  state <= imem_i_rvalid ? S_REQ : S_DROP;
        S_REQ:   state <= S_REQ;
        S_HOLD:  state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_i_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_i_rvalid) begin
            if (ctrl_i_fetch_stall) begin
              inst_q <= imem_i_rdata;
              state  <= S_HOLD;
            end else begin
              pc_q  <= pred_pc;
              state <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!ctrl_i_fetch_stall) begin
            pc_q  <= pred_pc;
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_i_rvalid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit. A behavioural imem returns
// address-derived instructions with random latency; a transaction-level
// model tracks the architectural next PC, the outstanding request, and
// whether a fetched instruction is awaiting handoff.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_i_fetch_stall;
  logic        ctrl_i_redirect;
  logic [31:0] ctrl_i_redirect_pc;
  logic        imem_o_req;
  logic [31:0] imem_o_addr;
  logic        imem_i_ready;
  logic        imem_i_rvalid;
  logic [31:0] imem_i_rdata;
  logic [31:0] fetch_o_instr;
  logic [31:0] fetch_o_pc;
  logic [31:0] fetch_o_pre_pc;
  logic        fetch_o_commit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk                (clk),
    .rst                (rst),
    .ctrl_i_fetch_stall (ctrl_i_fetch_stall),
    .ctrl_i_redirect    (ctrl_i_redirect),
    .ctrl_i_redirect_pc (ctrl_i_redirect_pc),
    .imem_o_req         (imem_o_req),
    .imem_o_addr        (imem_o_addr),
    .imem_i_ready       (imem_i_ready),
    .imem_i_rvalid      (imem_i_rvalid),
    .imem_i_rdata       (imem_i_rdata),
    .fetch_o_instr      (fetch_o_instr),
    .fetch_o_pc         (fetch_o_pc),
    .fetch_o_pre_pc     (fetch_o_pre_pc),
    .fetch_o_commit     (fetch_o_commit)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int off);
    logic [31:0] o;
    o = off;
    return {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'h6F};
  endfunction

  function automatic logic [31:0] enc_br(input int off);
    logic [31:0] o;
    o = off;
    return {o[12], o[10:5], 5'd1, 5'd2, 3'd0, o[4:1], o[11], 7'h63};
  endfunction

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ (a >> 7);
    case ((a >> 2) % 8)
      0:       return enc_jal(-16);
      1:       return enc_jal(12);
      2:       return enc_br(-8);
      3:       return enc_br(8);
      4:       return {h[31:7], 7'h67};   // JALR: never predicted
      default: return {h[31:7], 7'h13};
    endcase
  endfunction

  // Expected next-PC prediction, from the instruction's architectural meaning.
  function automatic logic [31:0] predict(input logic [31:0] ins, input logic [31:0] pc);
`ifdef FETCH_BPRED_EN
    int off;
    if ((ins & 32'h7F) == 32'h6F) begin
      off = int'((((ins >> 31) & 32'd1) << 20) | (((ins >> 12) & 32'hFF) << 12) |
                 (((ins >> 20) & 32'd1) << 11) | (((ins >> 21) & 32'h3FF) << 1));
      if (off >= (1 << 20)) off = off - (1 << 21);
      return pc + 32'(off);
    end
    if ((ins & 32'h7F) == 32'h63) begin
      off = int'((((ins >> 31) & 32'd1) << 12) | (((ins >> 7) & 32'd1) << 11) |
                 (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1));
      if (off >= (1 << 12)) return pc + 32'(off - (1 << 13));
    end
    return pc + 32'd4;
`else
    return pc + 32'd4 + (ins & 32'd0);
`endif
  endfunction

  // Reference-model state
  logic [31:0] exp_pc;
  bit          pending;
  bit          resp_stale;
  int          resp_wait;
  logic [31:0] resp_addr;
  bit          held;
  int          handoffs;
  int          stall_left;
  bit          fresh, exp_commit, exp_req;
  logic [31:0] cur_ins;

  initial begin
    rst = 1'b1;
    ctrl_i_fetch_stall = 1'b0;
    ctrl_i_redirect    = 1'b0;
    ctrl_i_redirect_pc = 32'd0;
    imem_i_ready       = 1'b0;
    imem_i_rvalid      = 1'b0;
    imem_i_rdata       = 32'd0;
    exp_pc = 32'h8000_0000;
    pending = 1'b0; resp_stale = 1'b0; resp_wait = 0; resp_addr = 32'd0;
    held = 1'b0; handoffs = 0; stall_left = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Drive inputs for this cycle.
      imem_i_rvalid = 1'b0;
      imem_i_rdata  = $urandom;
      if (pending) begin
        resp_wait--;
        if (resp_wait == 0) begin
          imem_i_rvalid = 1'b1;
          imem_i_rdata  = mem(resp_addr);
        end
      end
      if (cyc < 40) begin
        imem_i_ready       = 1'b1;
        ctrl_i_fetch_stall = 1'b0;
        ctrl_i_redirect    = 1'b0;
      end else begin
        imem_i_ready = ($urandom_range(0, 3) != 0);
        if (stall_left > 0) begin
          stall_left--;
          ctrl_i_fetch_stall = 1'b1;
        end else if ($urandom_range(0, 4) == 0) begin
          stall_left = $urandom_range(0, 4);
          ctrl_i_fetch_stall = 1'b1;
        end else begin
          ctrl_i_fetch_stall = 1'b0;
        end
        ctrl_i_redirect = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0)
          ctrl_i_redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else
          ctrl_i_redirect_pc = 32'h8000_0000 + 32'($urandom_range(0, 1023));
      end

      @(negedge clk);
      if (cyc == 0) begin
        chk("reset_req", {31'd0, imem_o_req}, 32'd1);
        chk("reset_addr", imem_o_addr, 32'h8000_0000);
        chk("reset_commit", {31'd0, fetch_o_commit}, 32'd0);
        chk("reset_instr", fetch_o_instr, 32'h0000_0013);
      end

      fresh      = imem_i_rvalid && !resp_stale;
      exp_commit = !ctrl_i_redirect && (fresh || held);
      exp_req    = !ctrl_i_redirect && !pending && !held;
      chk("commit", {31'd0, fetch_o_commit}, {31'd0, exp_commit});
      chk("req", {31'd0, imem_o_req}, {31'd0, exp_req});
      if (imem_o_req) chk("addr", imem_o_addr, exp_pc);
      cur_ins = mem(exp_pc);
      if (exp_commit) begin
        chk("pc", fetch_o_pc, exp_pc);
        chk("instr", fetch_o_instr, cur_ins);
        chk("pre_pc", fetch_o_pre_pc, predict(cur_ins, exp_pc));
      end else begin
        chk("nop_instr", fetch_o_instr, 32'h0000_0013);
        chk("nop_pc", fetch_o_pc, 32'd0);
        chk("nop_pre_pc", fetch_o_pre_pc, 32'd0);
      end

      // Advance the model to the coming clock edge.
      if (imem_i_rvalid) pending = 1'b0;
      if (ctrl_i_redirect) begin
        exp_pc = ctrl_i_redirect_pc & ~32'd3;
        held   = 1'b0;
        if (pending) resp_stale = 1'b1;
      end else if (exp_commit) begin
        if (!ctrl_i_fetch_stall) begin
          exp_pc = predict(cur_ins, exp_pc);
          handoffs++;
          held = 1'b0;
        end else begin
          held = 1'b1;
        end
      end
      if (imem_o_req && imem_i_ready) begin
        pending    = 1'b1;
        resp_stale = 1'b0;
        resp_addr  = imem_o_addr;
        resp_wait  = (cyc < 40) ? 1 : $urandom_range(1, 3);
      end

      if (cyc == 39) chk("throughput", handoffs, 32'd20);

      @(posedge clk);
      #1;
    end

    chk("progress", {31'd0, handoffs > 150}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
